// File: rtl/axi4_lite_slave_bridge.sv
// AXI4-Lite slave front-end driving the wreq/rreq register bus.
// One outstanding write and one outstanding read; missing acks time out to SLVERR.
module axi4_lite_slave_bridge #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  axi_clk,
    input  logic                  axi_rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  axi_wreq,
    output logic [13:0]           axi_waddr,
    output logic [31:0]           axi_wdata,
    input  logic                  axi_wack,
    output logic                  axi_rreq,
    output logic [13:0]           axi_raddr,
    input  logic [31:0]           axi_rdata,
    input  logic                  axi_rack
);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} rstate_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;

    // ---------------- write path ----------------
    wstate_t     wstate_q, wstate_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic [13:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        aw_hs, w_hs;
    logic [3:0]  wstrb_eff;

    assign s_axi_awready = (wstate_q == W_IDLE) && !aw_held_q;
    assign s_axi_wready  = (wstate_q == W_IDLE) && !w_held_q;
    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign w_hs          = s_axi_wvalid && s_axi_wready;
    assign wstrb_eff     = w_hs ? s_axi_wstrb : wstrb_q;

    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        wcnt_d    = wcnt_q;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    waddr_d   = s_axi_awaddr[15:2];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                end
                // Leave as soon as both halves are present, whichever arrived last.
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    if (wstrb_eff != 4'hF) begin
                        wstate_d = W_RESP;
                        bresp_d  = RESP_SLVERR;
                    end else begin
                        wstate_d = W_REQ;
                        wcnt_d   = 8'd0;
                    end
                end
            end
            W_REQ:  wstate_d = W_WAIT;
            W_WAIT: begin
                if (axi_wack) begin
                    wstate_d = W_RESP;
                    bresp_d  = RESP_OKAY;
                end else if (wcnt_q == TIMEOUT_LIMIT) begin
                    wstate_d = W_RESP;
                    bresp_d  = RESP_SLVERR;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            W_RESP: if (s_axi_bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            wstate_q  <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= '0;
            wcnt_q    <= '0;
        end else begin
            wstate_q  <= wstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign axi_wreq     = (wstate_q == W_REQ);
    assign axi_waddr    = waddr_q;
    assign axi_wdata    = wdata_q;
    assign s_axi_bvalid = (wstate_q == W_RESP);
    assign s_axi_bresp  = bresp_q;

    // ---------------- read path ----------------
    rstate_t     rstate_q, rstate_d;
    logic [13:0] raddr_q, raddr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [7:0]  rcnt_q, rcnt_d;

    assign s_axi_arready = (rstate_q == R_IDLE);

    always_comb begin
        rstate_d = rstate_q;
        raddr_d  = raddr_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rcnt_d   = rcnt_q;
        case (rstate_q)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    raddr_d  = s_axi_araddr[15:2];
                    rcnt_d   = 8'd0;
                    rstate_d = R_REQ;
                end
            end
            R_REQ:  rstate_d = R_WAIT;
            R_WAIT: begin
                if (axi_rack) begin
                    rdata_d  = axi_rdata;
                    rresp_d  = RESP_OKAY;
                    rstate_d = R_RESP;
                end else if (rcnt_q == TIMEOUT_LIMIT) begin
                    rdata_d  = 32'd0;
                    rresp_d  = RESP_SLVERR;
                    rstate_d = R_RESP;
                end else begin
                    rcnt_d = rcnt_q + 8'd1;
                end
            end
            R_RESP: if (s_axi_rready) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            rstate_q <= R_IDLE;
            raddr_q  <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            rcnt_q   <= '0;
        end else begin
            rstate_q <= rstate_d;
            raddr_q  <= raddr_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rcnt_q   <= rcnt_d;
        end
    end

    assign axi_rreq     = (rstate_q == R_REQ);
    assign axi_raddr    = raddr_q;
    assign s_axi_rvalid = (rstate_q == R_RESP);
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;

    // Byte-offset bits and bits above 15 carry no meaning for the register bus.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

endmodule

// File: tb/tb_axi4_lite_slave_bridge.sv
// Directed bench for axi4_lite_slave_bridge with a small register-block responder
// that acknowledges word addresses 0x800-0x8FF one cycle after each request.
module tb_axi4_lite_slave_bridge;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b0, rready = 1'b1;
    logic [31:0] wdata_in = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        wreq, rreq, wack, rack;
    logic [13:0] waddr, raddr;
    logic [31:0] wdata_reg, rdata_reg;
    logic        ack_en = 1'b1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    axi4_lite_slave_bridge #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
        .axi_clk(clk), .axi_rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata_in), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .axi_wreq(wreq), .axi_waddr(waddr), .axi_wdata(wdata_reg), .axi_wack(wack),
        .axi_rreq(rreq), .axi_raddr(raddr), .axi_rdata(rdata_reg), .axi_rack(rack)
    );

    // Register-block model: unwritten words read as {16'hC0DE, 8'h00, index}.
    bit [31:0] mem     [256];
    bit        written [256];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wack      <= 1'b0;
            rack      <= 1'b0;
            rdata_reg <= '0;
        end else begin
            wack <= wreq && ack_en && (waddr[13:8] == 6'h08);
            rack <= rreq && ack_en && (raddr[13:8] == 6'h08);
            if (wreq && ack_en && waddr[13:8] == 6'h08) begin
                mem[waddr[7:0]]     <= wdata_reg;
                written[waddr[7:0]] <= 1'b1;
            end
            rdata_reg <= written[raddr[7:0]] ? mem[raddr[7:0]] : {16'hC0DE, 8'h00, raddr[7:0]};
        end
    end

    // Monitor: monotonic event counters sampled mid-cycle.
    int cyc = 0, wreq_n = 0, rreq_n = 0, bv_n = 0, wreq_cyc = 0, bv_rise_cyc = 0;
    logic [13:0] m_waddr = '0, m_raddr = '0;
    logic [31:0] m_wdata = '0;
    logic        bv_prev = 1'b0;
    always @(negedge clk) begin
        cyc     <= cyc + 1;
        bv_prev <= bvalid;
        if (wreq) begin
            wreq_n   <= wreq_n + 1;
            wreq_cyc <= cyc;
            m_waddr  <= waddr;
            m_wdata  <= wdata_reg;
        end
        if (rreq) begin
            rreq_n  <= rreq_n + 1;
            m_raddr <= raddr;
        end
        if (bvalid) bv_n <= bv_n + 1;
        if (bvalid && !bv_prev) bv_rise_cyc <= cyc;
    end

    // Drives AW and W together; hold=0 keeps bready high throughout, else stalls hold cycles.
    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int hold, output logic [1:0] resp, output bit ok);
        int  n;
        bit  aw_f, w_f;
        ok = 1'b0;
        resp = 2'bxx;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1; wdata_in = d; wstrb = s; wvalid = 1'b1;
        bready = (hold == 0);
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(negedge clk);
            if (aw_f) awvalid = 1'b0;
            if (w_f)  wvalid  = 1'b0;
            n++;
        end
        n = 0;
        while (!bvalid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) begin
            awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
            return;
        end
        resp = bresp;
        repeat (hold) @(negedge clk);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        ok = 1'b1;
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output bit ok);
        int n;
        bit ar_f;
        ok = 1'b0;
        d = 'x;
        resp = 2'bxx;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (arvalid && n < 50) begin
            ar_f = arready;
            @(negedge clk);
            if (ar_f) arvalid = 1'b0;
            n++;
        end
        n = 0;
        while (!rvalid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) begin
            arvalid = 1'b0;
            return;
        end
        d = rdata;
        resp = rresp;
        @(negedge clk);
        ok = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({awready, wready, arready, bvalid, rvalid, wreq, rreq} !== 7'b1110000) begin
            bad++;
            $display("FAIL reset_ctrl actual=%b required=1110000",
                     {awready, wready, arready, bvalid, rvalid, wreq, rreq});
        end
        total++;
        if ({bresp, rresp, rdata, waddr, raddr, wdata_reg} !== '0) begin
            bad++;
            $display("FAIL reset_data bresp=%h rresp=%h rdata=%h waddr=%h raddr=%h wdata=%h required=0",
                     bresp, rresp, rdata, waddr, raddr, wdata_reg);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_ok();
        logic [1:0] resp;
        bit ok;
        int w0, b0;
        w0 = wreq_n; b0 = bv_n;
        axi_write(16'h2004, 32'hDEADBEEF, 4'hF, 0, resp, ok);
        #1;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL wr_done actual=%0d required=1", ok); end
        total++; if (wreq_n - w0 !== 1) begin bad++; $display("FAIL wr_wreq_count actual=%0d required=1", wreq_n - w0); end
        total++; if (m_waddr !== 14'h0801) begin bad++; $display("FAIL wr_waddr actual=%h required=0801", m_waddr); end
        total++; if (m_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_wdata actual=%h required=deadbeef", m_wdata); end
        total++; if (resp !== 2'b00) begin bad++; $display("FAIL wr_bresp actual=%b required=00", resp); end
        total++; if (bv_n - b0 !== 1) begin bad++; $display("FAIL wr_bvalid_cycles actual=%0d required=1", bv_n - b0); end
        total++; if (bv_rise_cyc - wreq_cyc !== 2) begin bad++; $display("FAIL wr_ack_latency actual=%0d required=2", bv_rise_cyc - wreq_cyc); end
    endtask

    task automatic test_read_back();
        logic [31:0] d;
        logic [1:0] resp;
        bit ok;
        int r0;
        r0 = rreq_n;
        axi_read(16'h2004, d, resp, ok);
        #1;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rd_done actual=%0d required=1", ok); end
        total++; if (rreq_n - r0 !== 1) begin bad++; $display("FAIL rd_rreq_count actual=%0d required=1", rreq_n - r0); end
        total++; if (m_raddr !== 14'h0801) begin bad++; $display("FAIL rd_raddr actual=%h required=0801", m_raddr); end
        total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata actual=%h required=deadbeef", d); end
        total++; if (resp !== 2'b00) begin bad++; $display("FAIL rd_rresp actual=%b required=00", resp); end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        logic [1:0] resp;
        bit ok;
        int w0;
        w0 = wreq_n;
        axi_write(16'h0000, 32'h11223344, 4'hF, 0, resp, ok);
        #1;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL to_wr_done actual=%0d required=1", ok); end
        total++; if (wreq_n - w0 !== 1) begin bad++; $display("FAIL to_wreq_count actual=%0d required=1", wreq_n - w0); end
        total++; if (resp !== 2'b10) begin bad++; $display("FAIL to_bresp actual=%b required=10", resp); end
        total++; if (bv_rise_cyc - wreq_cyc !== TO + 2) begin bad++; $display("FAIL to_latency actual=%0d required=%0d", bv_rise_cyc - wreq_cyc, TO + 2); end
        axi_read(16'h0000, d, resp, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL to_rd_done actual=%0d required=1", ok); end
        total++; if (d !== 32'h0) begin bad++; $display("FAIL to_rdata actual=%h required=0", d); end
        total++; if (resp !== 2'b10) begin bad++; $display("FAIL to_rresp actual=%b required=10", resp); end
    endtask

    task automatic test_partial_strobe();
        logic [1:0] resp;
        bit ok;
        int w0;
        w0 = wreq_n;
        axi_write(16'h2000, 32'h12345678, 4'h3, 0, resp, ok);
        #1;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL ps_done actual=%0d required=1", ok); end
        total++; if (wreq_n - w0 !== 0) begin bad++; $display("FAIL ps_wreq_count actual=%0d required=0", wreq_n - w0); end
        total++; if (resp !== 2'b10) begin bad++; $display("FAIL ps_bresp actual=%b required=10", resp); end
    endtask

    task automatic test_aw_early_stall();
        int w0, n, aw_err, stab_err;
        logic [1:0] held;
        w0 = wreq_n; aw_err = 0; stab_err = 0;
        @(negedge clk);
        awaddr = 16'h2010; awvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0;
        repeat (3) begin
            if (awready !== 1'b0) aw_err++;
            @(negedge clk);
        end
        wdata_in = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 60) begin
            if (awready !== 1'b0) aw_err++;
            @(negedge clk);
            n++;
        end
        total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL st_bvalid_seen actual=%b required=1", bvalid); end
        held = bresp;
        repeat (5) begin
            @(negedge clk);
            if (bvalid !== 1'b1 || bresp !== held) stab_err++;
            if (awready !== 1'b0) aw_err++;
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        #1;
        total++; if (held !== 2'b00) begin bad++; $display("FAIL st_bresp actual=%b required=00", held); end
        total++; if (stab_err !== 0) begin bad++; $display("FAIL st_stall_stable actual=%0d required=0", stab_err); end
        total++; if (aw_err !== 0) begin bad++; $display("FAIL st_awready_low actual=%0d required=0", aw_err); end
        total++; if (wreq_n - w0 !== 1) begin bad++; $display("FAIL st_wreq_count actual=%0d required=1", wreq_n - w0); end
        total++; if (m_wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL st_wdata actual=%h required=cafef00d", m_wdata); end
        total++; if ({bvalid, awready, wready} !== 3'b011) begin bad++; $display("FAIL st_after_b actual=%b required=011", {bvalid, awready, wready}); end
    endtask

    task automatic test_concurrent();
        logic [1:0] bres, rres;
        logic [31:0] d;
        bit wok, rok;
        int w0, r0;
        w0 = wreq_n; r0 = rreq_n;
        fork
            axi_write(16'h2008, 32'h0BADF00D, 4'hF, 0, bres, wok);
            axi_read(16'h200C, d, rres, rok);
        join
        #1;
        total++; if ({wok, rok} !== 2'b11) begin bad++; $display("FAIL cc_done actual=%b required=11", {wok, rok}); end
        total++; if (wreq_n - w0 !== 1 || rreq_n - r0 !== 1) begin bad++; $display("FAIL cc_req_counts actual=%0d/%0d required=1/1", wreq_n - w0, rreq_n - r0); end
        total++; if ({bres, rres} !== 4'b0000) begin bad++; $display("FAIL cc_resps actual=%b/%b required=00/00", bres, rres); end
        total++; if (d !== 32'hC0DE0003) begin bad++; $display("FAIL cc_rdata actual=%h required=c0de0003", d); end
        total++; if (m_waddr !== 14'h0802 || m_raddr !== 14'h0803) begin bad++; $display("FAIL cc_addrs actual=%h/%h required=0802/0803", m_waddr, m_raddr); end
    endtask

    task automatic test_reset_midflight();
        int n, b0;
        ack_en = 1'b0;
        @(negedge clk);
        awaddr = 16'h2014; wdata_in = 32'h55AA55AA; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!wreq && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++; if (wreq !== 1'b1) begin bad++; $display("FAIL rm_wreq_seen actual=%b required=1", wreq); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if ({bvalid, awready, wready} !== 3'b011) begin bad++; $display("FAIL rm_in_reset actual=%b required=011", {bvalid, awready, wready}); end
        @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        b0 = bv_n;
        repeat (30) @(negedge clk);
        #1;
        total++; if (bv_n - b0 !== 0) begin bad++; $display("FAIL rm_stale_resp actual=%0d required=0", bv_n - b0); end
        bready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_ok();
        test_read_back();
        test_timeout();
        test_partial_strobe();
        test_aw_early_stall();
        test_concurrent();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
